// File: rtl/column_move_drain.sv
// column_move_drain: round-robin drain of the per-column move FIFOs, unpacking
// each word into single moves on a valid/ready stream and flagging board done.
module column_move_drain #(
  parameter int NCOL  = 8,
  parameter int SLOTS = 8,
  parameter int MW    = 19,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCOL-1:0]          col_done,
  input  logic [NCOL-1:0]          col_empty,
  input  logic [NCOL*SLOTS*MW-1:0] col_data,
  output logic [NCOL-1:0]          col_rden,
  output logic [MW-1:0]            move_out,
  output logic                     move_valid,
  input  logic                     move_ready,
  output logic [CW-1:0]            move_count,
  output logic                     done
);
  localparam int IW = $clog2(NCOL);
  localparam int KW = $clog2(SLOTS);
  localparam int WW = SLOTS * MW;
  typedef enum logic [1:0] {SCAN, WAIT, UNPACK, DONE} state_t;
  state_t          state_q;
  logic [IW-1:0]   rr_q, sel_q, pick;
  logic [KW-1:0]   k_q;
  logic [WW-1:0]   buf_q;
  logic [CW-1:0]   count_q;
  logic [MW-1:0]   slot;
  logic            found;
  // Walk downward so the column closest to rr_q wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = NCOL - 1; j >= 0; j--)
      if (!col_empty[IW'(rr_q + IW'(j))]) begin
        found = 1'b1;
        pick  = IW'(rr_q + IW'(j));
      end
  end
  assign slot       = buf_q[k_q*MW +: MW];
  assign col_rden   = (state_q == SCAN && found && !reset) ? NCOL'(1) << pick : '0;
  assign move_valid = state_q == UNPACK && !slot[MW-1];
  assign move_out   = move_valid ? slot : '0;
  assign move_count = count_q;
  assign done       = state_q == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      rr_q    <= '0;
      sel_q   <= '0;
      k_q     <= '0;
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (found) begin
            sel_q   <= pick;
            state_q <= WAIT;
          end else if (&col_done) state_q <= DONE;
        end
        WAIT: begin
          buf_q   <= col_data[sel_q*WW +: WW];
          k_q     <= '0;
          rr_q    <= sel_q + 1'b1;
          state_q <= UNPACK;
        end
        UNPACK: begin
          if (slot[MW-1] || move_ready) begin
            k_q <= k_q + 1'b1;
            if (k_q == KW'(SLOTS - 1)) state_q <= SCAN;
            if (move_valid && count_q != '1) count_q <= count_q + 1'b1;
          end
        end
        default: state_q <= DONE;
      endcase
    end
  end
endmodule

// File: doc/column_move_drain.md
Name: column_move_drain

Overview:
Board-level reader for the eight per-column move FIFOs filled by the column units. Each FIFO entry is a 152-bit word packing eight 19-bit moves. This block drains the column FIFOs round-robin, unpacks each word, discards slots flagged invalid, and streams individual moves over a valid/ready handshake to the move-evaluation stage. It asserts done once every column has reported done and every move has been delivered.

Parameters:
NCOL, 8, number of column FIFOs (fixed at 8 for chess)
SLOTS, 8, moves packed per FIFO word
MW, 19, move width: [7b flag][6b from][6b to], flag MSB (bit 18) = invalid
CW, 8, width of move counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; also restarts a new board scan
col_done  in  8  done flag per column (bit i = column xpos i)
col_empty  in  8  FIFO empty flag per column
col_data  in  1216  column i rd data at [152*i+151 : 152*i]
col_rden  out  8  one-hot FIFO read enable
move_out  out  19  current move
move_valid  out  1  move_out valid
move_ready  in  1  downstream accepts move
move_count  out  8  moves delivered since reset, saturating at 255
done  out  1  all columns done, drained, last move accepted; sticky until reset

Behaviour:
- Reset values: col_rden=0, move_out=0, move_valid=0, move_count=0, done=0, rr_ptr=0, state=SCAN.
- FIFO read latency is fixed at 1: data for a rden pulse is sampled on col_data the cycle after the pulse. rden is a single-cycle pulse, at most one bit set.
- States:
  - SCAN: search columns rr_ptr, rr_ptr+1 ... (mod 8) for the first with col_empty=0. If one is found, pulse col_rden[i], latch sel=i, and go to WAIT. If none is found and col_done=8'hFF with col_empty=8'hFF, go to DONE. Otherwise stay in SCAN, because columns are still producing.
  - WAIT: one cycle. Capture col_data[sel] into buf, load slot index=0, set rr_ptr=sel+1 (wraps 7->0), go to UNPACK.
  - UNPACK: handle slot k = buf[19k+18:19k].
    - If bit18=1: skip it with move_valid=0 for that cycle (one cycle per skipped slot).
    - Else: drive move_out=slot with move_valid=1, held stable until move_ready=1. On the handshake, increment move_count (saturating) and advance k.
    - After slot 7 is skipped or accepted, return to SCAN.
  - DONE: done=1, move_valid=0, col_rden=0. Stay until reset.
- move_valid must not drop and move_out must not change while move_ready=0.
- A word with all 8 slots invalid produces zero moves: 8 UNPACK cycles, then SCAN.
- Column done while its FIFO is non-empty: keep draining; done needs both conditions for all columns.
- Empty flag rising again after a column was drained (late writes): served normally.
- reset mid-UNPACK: the buffered word is discarded, all outputs return to reset values next cycle, and no rden is issued in the reset cycle.
- col_rden is never asserted to a column whose col_empty=1 in the same cycle.

Test Plan:
- Column 3 holds one word: slots 0,1 valid (0x00ABC, 0x01234), slots 2-7 bit18=1; move_ready=1; col_done=FF after the write. Expect col_rden=8'h08 for exactly one cycle, moves 0x00ABC then 0x01234, move_count=2, done=1 after drain.
- Columns 0, 2 and 7 each hold one all-valid word, all non-empty at the same time. Expect service order 0, 2, 7 (round-robin from rr_ptr=0), 24 moves, move_count=24.
- Backpressure: move_ready=0 for 5 cycles while slot 0 is valid. Expect move_out/move_valid stable and no further rden; after ready rises, moves resume in order with none lost or duplicated.
- col_done=FF but column 5 is still non-empty with 2 words. Expect done=0 until both words are unpacked and the last move is accepted, then done=1 and it remains 1.
- 300 valid moves total. Expect move_count saturates at 255 and done still asserts.
- reset asserted during UNPACK of column 1. Expect move_valid=0, count=0, done=0 the next cycle; the next scan starts from column 0.
